router_fsm: RTL and testbench

- Control FSM of the 1x3 router. It sits between the input packet interface and the register/synchroniser/FIFO datapath.
- Decodes the 2-bit destination address in the header byte, then sequences loading of header, payload and parity.
- Stalls the sender (busy) when the destination FIFO is occupied or full, and arms internal-parity check/reset.
- Abandons a packet when the addressed FIFO's soft reset fires.

---
 rtl/router_pkg.sv | 34 +++
 rtl/router_fsm_if.sv | 42 ++++
 rtl/router_fsm.sv | 87 ++++++++
 tb/tb_router_fsm.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router: controller state encoding
// and destination address values used by the FSM, synchroniser and top level.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_0       = 2'b00;
    localparam logic [1:0] ADDR_1       = 2'b01;
    localparam logic [1:0] ADDR_2       = 2'b10;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Per-destination flag select; the invalid address selects nothing.
    function automatic logic pick_flag(input logic [1:0] addr,
                                       input logic f0,
                                       input logic f1,
                                       input logic f2);
        case (addr)
            ADDR_0:  pick_flag = f0;
            ADDR_1:  pick_flag = f1;
            ADDR_2:  pick_flag = f2;
            default: pick_flag = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Control-path bundle between the router FSM and the sender / register /
// synchroniser / FIFO blocks around it.
interface router_fsm_if;
    // Handshake: the sender presents a byte with pkt_valid high and holds it
    // while busy is high; a byte is consumed on a rising edge where busy is low.
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;

    modport master (
        output pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );

    modport slave (
        input  pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );
endinterface

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences header/payload/
// parity loading, stalls the sender and abandons packets on soft reset.
module router_fsm
    import router_pkg::*;
(
    input  logic         clock,
    input  logic         resetn,
    router_fsm_if.slave  bus,
    output state_t       state_dbg_o,
    output logic [1:0]   addr_dbg_o
);

    state_t     state_q;
    logic [1:0] addr_q;
    logic       hdr_ok;
    logic       empty_dec;
    logic       empty_wait;
    logic       soft_hit;

    assign hdr_ok     = bus.pkt_valid && (bus.data_in != ADDR_INVALID);
    assign empty_dec  = pick_flag(bus.data_in, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2);
    assign empty_wait = pick_flag(addr_q, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2);
    assign soft_hit   = pick_flag(addr_q, bus.soft_reset_0, bus.soft_reset_1, bus.soft_reset_2);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= ADDR_0;
        end else begin
            if (state_q == DECODE_ADDRESS && hdr_ok)
                addr_q <= bus.data_in;

            // Soft reset of the addressed FIFO abandons the packet outright.
            if (state_q != DECODE_ADDRESS && soft_hit) begin
                state_q <= DECODE_ADDRESS;
            end else begin
                case (state_q)
                    DECODE_ADDRESS:
                        if (hdr_ok)
                            state_q <= empty_dec ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    LOAD_FIRST_DATA:
                        state_q <= LOAD_DATA;
                    LOAD_DATA:
                        if (bus.fifo_full)
                            state_q <= FIFO_FULL_STATE;
                        else if (!bus.pkt_valid)
                            state_q <= LOAD_PARITY;
                    LOAD_PARITY:
                        state_q <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR:
                        state_q <= bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                    FIFO_FULL_STATE:
                        if (!bus.fifo_full)
                            state_q <= LOAD_AFTER_FULL;
                    LOAD_AFTER_FULL:
                        if (bus.parity_done)
                            state_q <= DECODE_ADDRESS;
                        else if (bus.low_pkt_valid)
                            state_q <= LOAD_PARITY;
                        else
                            state_q <= LOAD_DATA;
                    WAIT_TILL_EMPTY:
                        if (empty_wait)
                            state_q <= LOAD_FIRST_DATA;
                    default:
                        state_q <= DECODE_ADDRESS;
                endcase
            end
        end
    end

    // Moore decodes straight off the state register, so async reset is
    // visible on the outputs without a clock edge.
    assign bus.detect_add    = (state_q == DECODE_ADDRESS);
    assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_q == LOAD_DATA);
    assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    assign bus.full_state    = (state_q == FIFO_FULL_STATE);
    assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                               (state_q == LOAD_AFTER_FULL);
    assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign bus.busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);

    assign state_dbg_o = state_q;
    assign addr_dbg_o  = addr_q;

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: reset, normal packet, occupied destination,
// full-FIFO recovery paths, invalid address and soft reset.
module tb_router_fsm;
    import router_pkg::*;

    logic       clock;
    logic       resetn;
    state_t     state_dbg;
    logic [1:0] addr_dbg;
    logic [7:0] obs_out;
    int         total;
    int         bad;
    int         wen_cnt;
    int         rir_cnt;
    int         wte_cnt;
    logic [7:0] exp_q[$];

    router_fsm_if ifc ();

    router_fsm u_dut (
        .clock       (clock),
        .resetn      (resetn),
        .bus         (ifc.slave),
        .state_dbg_o (state_dbg),
        .addr_dbg_o  (addr_dbg)
    );

    // Output vector: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    assign obs_out = {ifc.detect_add, ifc.lfd_state, ifc.ld_state, ifc.laf_state,
                      ifc.full_state, ifc.write_enb_reg, ifc.rst_int_reg, ifc.busy};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] exp_out(input state_t s);
        case (s)
            DECODE_ADDRESS:     exp_out = 8'h80;
            LOAD_FIRST_DATA:    exp_out = 8'h41;
            LOAD_DATA:          exp_out = 8'h24;
            LOAD_PARITY:        exp_out = 8'h05;
            CHECK_PARITY_ERROR: exp_out = 8'h03;
            FIFO_FULL_STATE:    exp_out = 8'h09;
            LOAD_AFTER_FULL:    exp_out = 8'h15;
            default:            exp_out = 8'h01;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input state_t s);
        chk({tag, "_state"}, 8'(state_dbg), 8'(s));
        chk({tag, "_outs"}, obs_out, exp_out(s));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.pkt_valid     = 1'b0;
        ifc.data_in       = 2'b00;
        ifc.parity_done   = 1'b0;
        ifc.low_pkt_valid = 1'b0;
        ifc.fifo_full     = 1'b0;
        ifc.fifo_empty_0  = 1'b1;
        ifc.fifo_empty_1  = 1'b1;
        ifc.fifo_empty_2  = 1'b1;
        ifc.soft_reset_0  = 1'b0;
        ifc.soft_reset_1  = 1'b0;
        ifc.soft_reset_2  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        resetn = 1'b0;
        #2;
        chk_state("reset", DECODE_ADDRESS);
        chk("reset_addr", {6'd0, addr_dbg}, 8'h00);
        step();
        step();
        resetn = 1'b1;
        step();
        chk_state("idle", DECODE_ADDRESS);

        // Normal packet to port 1: pkt_valid high for 5 edges, then low.
        ifc.data_in = ADDR_1;
        exp_q.push_back(8'(LOAD_FIRST_DATA));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(LOAD_DATA));
        exp_q.push_back(8'(LOAD_PARITY));
        exp_q.push_back(8'(CHECK_PARITY_ERROR));
        exp_q.push_back(8'(DECODE_ADDRESS));
        wen_cnt = 0;
        rir_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            ifc.pkt_valid = (i < 5);
            step();
            if (ifc.write_enb_reg) wen_cnt++;
            if (ifc.rst_int_reg) rir_cnt++;
            chk_state($sformatf("pkt1_%0d", i), state_t'(exp_q.pop_front()));
        end
        chk("pkt1_addr", {6'd0, addr_dbg}, 8'h01);
        chk("pkt1_wen_cycles", 8'(wen_cnt), 8'd5);
        chk("pkt1_rir_cycles", 8'(rir_cnt), 8'd1);

        // Async reset in the middle of LOAD_DATA.
        ifc.pkt_valid = 1'b1;
        ifc.data_in   = ADDR_0;
        step();
        step();
        chk_state("pre_rst", LOAD_DATA);
        #2;
        resetn = 1'b0;
        #1;
        chk_state("async_rst", DECODE_ADDRESS);
        chk("async_rst_addr", {6'd0, addr_dbg}, 8'h00);
        ifc.pkt_valid = 1'b0;
        #1;
        resetn = 1'b1;
        step();
        chk_state("post_rst", DECODE_ADDRESS);

        // Occupied destination 2: wait 6 cycles while fifo_empty_0 toggles.
        ifc.pkt_valid    = 1'b1;
        ifc.data_in      = ADDR_2;
        ifc.fifo_empty_2 = 1'b0;
        wte_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            ifc.pkt_valid    = 1'b0;
            ifc.fifo_empty_0 = ~ifc.fifo_empty_0;
            if (state_dbg == WAIT_TILL_EMPTY && ifc.busy) wte_cnt++;
        end
        chk_state("wait_end", WAIT_TILL_EMPTY);
        chk("wait_cycles", 8'(wte_cnt), 8'd6);
        chk("wait_addr", {6'd0, addr_dbg}, 8'h02);
        ifc.fifo_empty_2 = 1'b1;
        ifc.fifo_empty_0 = 1'b1;
        step();
        chk_state("wait_lfd", LOAD_FIRST_DATA);
        ifc.pkt_valid = 1'b1;
        step();
        chk_state("wait_ld", LOAD_DATA);

        // Full during load, then release with neither flag -> LAF -> LD.
        ifc.fifo_full = 1'b1;
        step();
        chk_state("full1", FIFO_FULL_STATE);
        step();
        chk_state("full1_hold", FIFO_FULL_STATE);
        ifc.fifo_full = 1'b0;
        step();
        chk_state("laf1", LOAD_AFTER_FULL);
        step();
        chk_state("laf1_ld", LOAD_DATA);

        // Full again, release with low_pkt_valid -> LAF -> LP -> CPE -> DA.
        ifc.fifo_full = 1'b1;
        step();
        chk_state("full2", FIFO_FULL_STATE);
        ifc.fifo_full     = 1'b0;
        ifc.low_pkt_valid = 1'b1;
        step();
        chk_state("laf2", LOAD_AFTER_FULL);
        ifc.pkt_valid = 1'b0;
        step();
        chk_state("laf2_lp", LOAD_PARITY);
        ifc.low_pkt_valid = 1'b0;
        step();
        chk_state("laf2_cpe", CHECK_PARITY_ERROR);
        step();
        chk_state("laf2_da", DECODE_ADDRESS);

        // New packet to port 1, full, release with parity_done -> LAF -> DA.
        ifc.pkt_valid = 1'b1;
        ifc.data_in   = ADDR_1;
        step();
        chk_state("pkt3_lfd", LOAD_FIRST_DATA);
        step();
        chk_state("pkt3_ld", LOAD_DATA);
        ifc.fifo_full = 1'b1;
        step();
        chk_state("full3", FIFO_FULL_STATE);
        ifc.fifo_full   = 1'b0;
        ifc.parity_done = 1'b1;
        ifc.pkt_valid   = 1'b0;
        step();
        chk_state("laf3", LOAD_AFTER_FULL);
        step();
        chk_state("laf3_da", DECODE_ADDRESS);
        ifc.parity_done = 1'b0;

        // Invalid address is never accepted and leaves addr_q alone.
        ifc.pkt_valid = 1'b1;
        ifc.data_in   = ADDR_INVALID;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state($sformatf("inval_%0d", i), DECODE_ADDRESS);
            chk($sformatf("inval_addr_%0d", i), {6'd0, addr_dbg}, 8'h01);
        end

        // Soft reset: only the addressed FIFO's soft reset aborts.
        ifc.data_in      = ADDR_0;
        ifc.fifo_empty_0 = 1'b0;
        step();
        chk_state("sr_wait", WAIT_TILL_EMPTY);
        chk("sr_addr", {6'd0, addr_dbg}, 8'h00);
        ifc.pkt_valid    = 1'b0;
        ifc.soft_reset_1 = 1'b1;
        step();
        chk_state("sr1_ignored", WAIT_TILL_EMPTY);
        ifc.soft_reset_1 = 1'b0;
        ifc.soft_reset_0 = 1'b1;
        step();
        chk_state("sr0_abort", DECODE_ADDRESS);
        ifc.soft_reset_0 = 1'b0;
        step();
        chk_state("sr0_idle", DECODE_ADDRESS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
